// File: rtl/cic_pkg.sv
// Shared CIC helpers: ceil(log2) and the required integrator output width.
package cic_pkg;

    localparam int unsigned CIC_N_MIN = 1;
    localparam int unsigned CIC_N_MAX = 8;
    localparam int unsigned CIC_R_MIN = 2;

    // ceil(log2(value)), 0 for value <= 1
    function automatic int unsigned cic_clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'(1) << i) < 64'(value)) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

    // Bit growth of an N-stage CIC with decimation R and comb delay M
    function automatic int unsigned cic_out_width(
        input int unsigned inp_width,
        input int unsigned cic_n,
        input int unsigned cic_r,
        input int unsigned cic_m
    );
        return inp_width + cic_n * cic_clog2(cic_r * cic_m);
    endfunction

endpackage

// File: rtl/cic_integrator_decim_integrator.sv
// Single CIC integrator stage: accumulate on strobe, strobe delayed by one register.
// Optional synchronous clear port when CIC_INTEG_CLEAR_EN is defined.
module integrator #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
`ifdef CIC_INTEG_CLEAR_EN
    input  logic             clr,
`endif
    input  logic             str_in,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] acc,
    output logic             str_out
);

    // Modular accumulate; the strobe follows the data by exactly one register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc     <= '0;
            str_out <= 1'b0;
        end else begin
`ifdef CIC_INTEG_CLEAR_EN
            if (clr) begin
                acc     <= '0;
                str_out <= 1'b0;
            end else
`endif
            begin
                str_out <= str_in;
                if (str_in) begin
                    acc <= acc + data_in;
                end
            end
        end
    end

endmodule

// File: rtl/cic_integrator_decim.sv
// CIC decimator front half: CIC_N cascaded integrators then a rate-CIC_R downsampler.
// Optional feature macro: CIC_INTEG_CLEAR_EN adds integ_clr (synchronous restart).
module cic_integrator_decim
    import cic_pkg::*;
#(
    parameter int unsigned INP_WIDTH = 16,
    parameter int unsigned OUT_WIDTH = 32,
    parameter int unsigned CIC_N     = 3,
    parameter int unsigned CIC_R     = 8,
    parameter int unsigned CIC_M     = 1
) (
    input  logic                        clk,
    input  logic                        reset_n,
`ifdef CIC_INTEG_CLEAR_EN
    input  logic                        integ_clr,
`endif
    input  logic signed [INP_WIDTH-1:0] samp_inp_data,
    input  logic                        samp_inp_str,
    output logic signed [OUT_WIDTH-1:0] samp_out_data,
    output logic                        samp_out_str
);

    localparam int unsigned CNT_W     = cic_clog2(CIC_R);
    localparam int unsigned MIN_OUT_W = cic_out_width(INP_WIDTH, CIC_N, CIC_R, CIC_M);

    // Elaboration-time parameter sanity checks
    generate
        if (OUT_WIDTH < MIN_OUT_W) begin : g_width_check
            $error("cic_integrator_decim: OUT_WIDTH %0d below required %0d", OUT_WIDTH, MIN_OUT_W);
        end
        if (CIC_N < CIC_N_MIN || CIC_N > CIC_N_MAX) begin : g_n_check
            $error("cic_integrator_decim: CIC_N %0d out of range", CIC_N);
        end
        if (CIC_R < CIC_R_MIN) begin : g_r_check
            $error("cic_integrator_decim: CIC_R %0d below minimum", CIC_R);
        end
    endgenerate

    logic [CIC_N:0][OUT_WIDTH-1:0] stage_data;
    logic [CIC_N:0]                stage_str;
    logic [CNT_W-1:0]              dec_cnt;

    // Stage 0 is the sign-extended input
    assign stage_data[0] = OUT_WIDTH'(samp_inp_data);
    assign stage_str[0]  = samp_inp_str;

    // Integrator cascade
    generate
        for (genvar k = 1; k <= int'(CIC_N); k++) begin : g_integ
            integrator #(
                .WIDTH (OUT_WIDTH)
            ) u_integ (
                .clk     (clk),
                .reset_n (reset_n),
`ifdef CIC_INTEG_CLEAR_EN
                .clr     (integ_clr),
`endif
                .str_in  (stage_str[k-1]),
                .data_in (stage_data[k-1]),
                .acc     (stage_data[k]),
                .str_out (stage_str[k])
            );
        end
    endgenerate

    // Downsampler: emit the last stage every CIC_R-th strobe, hold data otherwise
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dec_cnt       <= '0;
            samp_out_data <= '0;
            samp_out_str  <= 1'b0;
        end else begin
`ifdef CIC_INTEG_CLEAR_EN
            if (integ_clr) begin
                dec_cnt       <= '0;
                samp_out_data <= '0;
                samp_out_str  <= 1'b0;
            end else
`endif
            if (stage_str[CIC_N]) begin
                if (dec_cnt == CNT_W'(CIC_R - 1)) begin
                    dec_cnt       <= '0;
                    samp_out_data <= stage_data[CIC_N];
                    samp_out_str  <= 1'b1;
                end else begin
                    dec_cnt      <= dec_cnt + CNT_W'(1);
                    samp_out_str <= 1'b0;
                end
            end else begin
                samp_out_str <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_cic_integrator_decim.sv
// Self-checking bench for cic_integrator_decim (N=3, R=8, 16->32 bits).
// Reference: each emitted sample is the N-fold running sum of all samples since
// the last restart, taken at every R-th sample, due N+1 edges after its input.
module tb_cic_integrator_decim;

    localparam int unsigned IW = 16;
    localparam int unsigned OW = 32;
    localparam int unsigned N  = 3;
    localparam int unsigned R  = 8;
    localparam int unsigned M  = 1;

    logic                 clk;
    logic                 reset_n;
    logic                 integ_clr;
    logic signed [IW-1:0] samp_inp_data;
    logic                 samp_inp_str;
    logic signed [OW-1:0] samp_out_data;
    logic                 samp_out_str;

    int n_cmp;
    int n_bad;
    int cyc;

    logic [OW-1:0] hist [$];
    int            due_q [$];
    logic [OW-1:0] val_q [$];
    logic [OW-1:0] last_exp;

    cic_integrator_decim #(
        .INP_WIDTH (IW),
        .OUT_WIDTH (OW),
        .CIC_N     (N),
        .CIC_R     (R),
        .CIC_M     (M)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
`ifdef CIC_INTEG_CLEAR_EN
        .integ_clr     (integ_clr),
`endif
        .samp_inp_data (samp_inp_data),
        .samp_inp_str  (samp_inp_str),
        .samp_out_data (samp_out_data),
        .samp_out_str  (samp_out_str)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // N-fold cumulative sum over the whole history, modulo 2^OW
    function automatic logic [OW-1:0] model_out();
        logic [OW-1:0] y [$];
        logic [OW-1:0] run;
        y = hist;
        for (int s = 0; s < int'(N); s++) begin
            run = '0;
            for (int i = 0; i < y.size(); i++) begin
                run  = run + y[i];
                y[i] = run;
            end
        end
        return y[y.size()-1];
    endfunction

    task automatic flush();
        hist.delete();
        due_q.delete();
        val_q.delete();
        last_exp = '0;
    endtask

    task automatic chk(input string tag, input logic [OW-1:0] obs, input logic [OW-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    // One clock: drive inputs, update the model, check outputs after the edge
    task automatic step(input logic s, input logic [IW-1:0] d, input logic c);
        int   e;
        logic exp_str;
        samp_inp_str  = s;
        samp_inp_data = d;
        integ_clr     = c;
        e = cyc + 1;
        if (reset_n) begin
            if (c) begin
                flush();
            end else if (s) begin
                hist.push_back({{(OW-IW){d[IW-1]}}, d});
                if (hist.size() % int'(R) == 0) begin
                    due_q.push_back(e + int'(N));
                    val_q.push_back(model_out());
                end
            end
        end
        @(posedge clk);
        #1;
        cyc = e;
        exp_str = 1'b0;
        if (due_q.size() > 0 && due_q[0] == cyc) begin
            exp_str  = 1'b1;
            last_exp = val_q[0];
            void'(due_q.pop_front());
            void'(val_q.pop_front());
        end
        chk("out_str", OW'(samp_out_str), OW'(exp_str));
        chk("out_data", samp_out_data, last_exp);
        samp_inp_str = 1'b0;
        integ_clr    = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0);
    endtask

    // Asynchronous reset between edges; outputs must clear immediately
    task automatic do_reset();
        reset_n = 1'b0;
        #1;
        flush();
        chk("rst_str", OW'(samp_out_str), '0);
        chk("rst_data", samp_out_data, '0);
        step(1'b0, '0, 1'b0);
        reset_n = 1'b1;
    endtask

    initial begin
        n_cmp         = 0;
        n_bad         = 0;
        cyc           = 0;
        reset_n       = 1'b0;
        integ_clr     = 1'b0;
        samp_inp_str  = 1'b0;
        samp_inp_data = '0;
        last_exp      = '0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        cyc = 2;
        chk("init_str", OW'(samp_out_str), '0);
        chk("init_data", samp_out_data, '0);
        reset_n = 1'b1;

        // Impulse: outputs C(n+2,2) at n=7,15,23 -> 36,136,300
        step(1'b1, 16'd1, 1'b0);
        for (int i = 0; i < 23; i++) step(1'b1, 16'd0, 1'b0);
        idle(5);
        chk("impulse_last", samp_out_data, 32'd300);

        // DC ones, continuous: C(n+3,3) -> 120, 816
        do_reset();
        for (int i = 0; i < 16; i++) step(1'b1, 16'd1, 1'b0);
        idle(5);
        chk("dc_last", samp_out_data, 32'd816);

        // Gapped strobes (every 5th cycle): same values, stretched timing
        do_reset();
        for (int i = 0; i < 16; i++) begin
            step(1'b1, 16'd1, 1'b0);
            idle(4);
        end
        idle(2);
        chk("gap_last", samp_out_data, 32'd816);

        // Random data with random strobe density
        do_reset();
        for (int i = 0; i < 300; i++) begin
            step(($urandom_range(0, 2) != 0), IW'($urandom), 1'b0);
        end
        idle(5);

        // Reset mid-group after 6 strobes, then a fresh group
        do_reset();
        for (int i = 0; i < 6; i++) step(1'b1, IW'($urandom), 1'b0);
        do_reset();
        for (int i = 0; i < 8; i++) step(1'b1, 16'd1, 1'b0);
        idle(5);
        chk("midrst_first", samp_out_data, 32'd120);

        // Long full-scale DC run forces accumulator wrap-around
        do_reset();
        for (int i = 0; i < 400; i++) step(1'b1, 16'h7fff, 1'b0);
        idle(5);
        do_reset();
        for (int i = 0; i < 400; i++) step(1'b1, 16'h8000, 1'b0);
        idle(5);

`ifdef CIC_INTEG_CLEAR_EN
        // Clear with a simultaneous strobe mid-group: sample dropped, fresh restart
        do_reset();
        for (int i = 0; i < 11; i++) step(1'b1, 16'd1, 1'b0);
        idle(4);
        step(1'b1, 16'h1234, 1'b1);
        chk("clr_data", samp_out_data, '0);
        for (int i = 0; i < 8; i++) step(1'b1, 16'd1, 1'b0);
        idle(5);
        chk("clr_first", samp_out_data, 32'd120);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/cic_integrator_decim.md
Name: cic_integrator_decim

Overview:
- Front half of the CIC decimator: CIC_N cascaded integrators followed by a rate-CIC_R downsampler.
- Sits directly upstream of the comb chain. Its samp_out_data / samp_out_str drive the first comb stage's samp_inp_data / samp_inp_str.
- Internal arithmetic is modular (two's complement wrap). The downstream combs cancel the wrap, so there is no saturation anywhere in this block.

Parameters:
- INP_WIDTH, 16: input sample width, signed.
- OUT_WIDTH, 32: accumulator and output width, signed. Requires OUT_WIDTH >= INP_WIDTH + CIC_N*ceil(log2(CIC_R*CIC_M)).
- CIC_N, 3: number of integrator stages, range 1..8.
- CIC_R, 8: decimation ratio, >= 2.
- CIC_M, 1: differential delay of the downstream comb. Used only in the width check.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- samp_inp_data  in  INP_WIDTH  signed input sample
- samp_inp_str  in  1  input sample strobe, may be asserted on every cycle
- samp_out_data  out  OUT_WIDTH  signed decimated sample
- samp_out_str  out  1  one-cycle output strobe, asserted once per CIC_R input strobes

Behaviour:
- Clocking and reset
  - Single clock domain; reset is asynchronous, active-low (clk, reset_n).
  - On reset: all integrator accumulators, the strobe pipeline, the decimation counter, samp_out_data and samp_out_str go to 0.
  - Reset asserted mid-operation discards in-flight samples. After release, the first output corresponds to the CIC_R-th strobe counted from release.
- Input handling
  - samp_inp_data is sign-extended to OUT_WIDTH before stage 1.
- Integrator pipeline
  - Stage k has a register acc[k] and a strobe str[k]. str[0] = samp_inp_str; str[k] <= str[k-1].
  - When str[k-1] = 1: acc[k] <= acc[k] + x[k-1], where x[0] is the extended input and x[k] = acc[k].
  - acc[k] holds when str[k-1] = 0.
  - Each stage adds exactly one register, so samples stay strobe-aligned even with back-to-back strobes.
- Arithmetic
  - All additions are OUT_WIDTH wide, with wrap-around and no overflow flag.
- Decimator
  - Counter dec_cnt, width clog2(CIC_R), reset value 0. It advances on str[CIC_N].
  - If dec_cnt == CIC_R-1 and str[CIC_N] = 1: samp_out_data <= acc[CIC_N], samp_out_str <= 1, dec_cnt <= 0.
  - Otherwise, on str[CIC_N] = 1: dec_cnt increments. samp_out_str <= 0 on every cycle without an emit.
- Latency and output holding
  - Input strobe to samp_out_str: CIC_N+1 cycles, for the strobe that completes a decimation group.
  - samp_out_data holds its value between output strobes.
- Boundary cases
  - Gapped input strobes: the pipeline and counter simply stall. There is no timeout.
  - Continuous strobes: one output every CIC_R cycles.

Optional Feature:
- Macro: CIC_INTEG_CLEAR_EN.
- When defined, the block gains an input port `integ_clr` (1 bit).
  - integ_clr = 1 synchronously zeroes every acc[k], str[k], dec_cnt and samp_out_str on the next clock edge. samp_out_data also goes to 0.
  - integ_clr has priority over any simultaneous strobe; the input sample presented in that cycle is dropped.
  - Use case: restarting the filter on a channel change without a global reset.
- When not defined, the port does not exist and there is no clear logic.

Decomposition:
- Shared package cic_pkg:
  - function `cic_out_width(INP_WIDTH, CIC_N, CIC_R, CIC_M)` for computing the output width;
  - a clog2 helper.
- One natural sub-module, `integrator`: a single accumulate-on-strobe stage with a registered strobe passthrough.
  - It is instantiated CIC_N times in a generate loop.
  - The decimation counter lives in the top module.
- An elaboration-time assertion checks OUT_WIDTH >= cic_out_width(...).

Test Plan:
1. Impulse. N=2, R=4, input 1 then zeros, strobe every cycle. The first samp_out_str arrives 3 cycles after the 4th input strobe with data 4; the next output is 8, then 12.
2. DC. N=2, R=4, constant 1. Outputs are 10, 36, 78 (stage-2 value (n+1)(n+2)/2 at n = 3, 7, 11).
3. Wrap-around. N=1, R=4, INP_WIDTH=4, OUT_WIDTH=6, constant 7.
   - Outputs are 28, then -8 (56 wrapped), then 20 (84-64).
   - Chaining a comb with M=1 must yield a constant 28.
4. Gapped strobes. N=3, R=8, strobe every 5th cycle, constant 1. Exactly one output per 8 input strobes. Values match the continuous-strobe run; only the timing stretches.
5. Reset mid-run. Assert reset_n=0 after 6 strobes (R=8). All outputs are immediately 0. The next output occurs after 8 fresh strobes and equals the fresh-start value.
6. (CIC_INTEG_CLEAR_EN) Pulse integ_clr together with a strobe mid-group. That sample is dropped, dec_cnt returns to 0, and the subsequent outputs match a fresh start.
